fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline. Produces the 16-bit instruction stream that the decoding stage consumes.
- Owns the PC and drives the instruction-memory address. Assembles two-word (immediate) instructions.
- Holds the IF/ID pipeline buffer. Honours stall and jump-redirect requests coming from later stages.

Parameters:
- ADDR_W, 16, PC and instruction-memory address width; PC wraps modulo 2^ADDR_W.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard stall: hold PC, FSM and IF/ID buffer
- jump_occured  in  1  taken branch/jump/call/ret resolved downstream; redirect fetch
- jump_target  in  ADDR_W  redirect address, valid when jump_occured=1
- imem_addr  out  ADDR_W  instruction-memory address (= PC, combinational)
- imem_data  in  16  instruction-memory word at imem_addr, asynchronous read (same cycle)
- instruction  out  16  IF/ID buffered instruction word to decode
- imm  out  16  IF/ID buffered immediate (second word); 0 for one-word instructions
- pc_buf  out  ADDR_W  IF/ID buffered address following the instruction (return address for CALL)
- valid_buf  out  1  IF/ID entry holds a real instruction; 0 = bubble

Behaviour:
- Reset (clk edge with reset=1):
  - pc<=RESET_PC, state<=FETCH, hold_word<=0.
  - instruction<=16'h0000 (NOP), imm<=0, pc_buf<=0, valid_buf<=0.
  - Reset overrides jump_occured and stall.
- Priority each edge: reset > jump_occured > stall > normal.
- FSM states: FETCH, IMM.
- FETCH, normal:
  - Opcode = imem_data[15:11].
  - If the opcode is not a two-word opcode:
    - instruction<=imem_data, imm<=0, pc_buf<=pc+1, valid_buf<=1.
    - pc<=pc+1. Stay in FETCH.
  - If the opcode is a two-word opcode:
    - hold_word<=imem_data, pc<=pc+1, state<=IMM.
    - IF/ID gets a bubble: instruction<=NOP, imm<=0, valid_buf<=0.
- IMM, normal:
  - instruction<=hold_word, imm<=imem_data, pc_buf<=pc+1, valid_buf<=1.
  - pc<=pc+1, state<=FETCH.
- Latency:
  - A one-word instruction at address A appears on instruction one edge after PC=A.
  - A two-word instruction at A appears one edge after PC=A+1, preceded by exactly one bubble.
  - Sustained throughput: one instruction per cycle (one-word), one per two cycles (two-word).
- stall=1, no jump: pc, state, hold_word, instruction, imm, pc_buf and valid_buf all hold. imem_addr keeps presenting pc.
- jump_occured=1 (any state, stall ignored):
  - pc<=jump_target, state<=FETCH.
  - IF/ID flushed: instruction<=NOP, imm<=0, valid_buf<=0. pc_buf holds.
  - Any half-assembled two-word instruction is discarded.
- Wrap-around:
  - pc+1 from all-ones wraps to 0. pc_buf wraps identically.
  - A two-word instruction at the last address takes its immediate from address 0.
- Reset asserted in IMM: the partial instruction is discarded; the next fetch starts at RESET_PC.

Decomposition:
- Shared package fetch_pkg:
  - OPC_LDM=5'b10100, OPC_LDD=5'b10101, OPC_STD=5'b10110 (two-word opcodes).
  - NOP_INSTR=16'h0000.
  - State enum {FETCH, IMM}.
  - Function is_two_word(opcode). The control unit reuses the same opcode constants.
- One natural sub-module: if_id_buffer (instruction/imm/pc_buf/valid_buf register with hold and flush inputs). PC and FSM stay in fetch_stage.

Test Plan:
- Reset then run:
  - Stimulus: RESET_PC=0; imem[0..2]={16'h0800,16'h1000,16'h1800}.
  - Required: imem_addr=0,1,2 on consecutive cycles; instruction=0800,1000,1800 one cycle later, each with valid_buf=1; pc_buf=1,2,3.
- Two-word:
  - Stimulus: imem[4]=16'hA200 (LDM), imem[5]=16'h1234.
  - Required: one cycle with valid_buf=0, then instruction=A200, imm=1234, pc_buf=6, valid_buf=1; next imem_addr=6.
- Stall:
  - Stimulus: assert stall for 3 cycles mid-stream.
  - Required: imem_addr, instruction and valid_buf stay frozen for 3 cycles; the stream resumes with no skipped or duplicated instruction.
- Jump with stall:
  - Stimulus: jump_occured=1, jump_target=16'h0040, stall=1 in the same cycle.
  - Required: next imem_addr=0040, instruction=0000, valid_buf=0; the word at 0040 is delivered on the following edge.
- Jump mid-immediate:
  - Stimulus: jump asserted while in IMM (after LDM first word), target=16'h0010.
  - Required: the LDM never appears with valid_buf=1; the next valid instruction is imem[0x10].
- Wrap and reset:
  - Stimulus: PC=16'hFFFF holding LDM, imem[0]=16'h00AA.
  - Required: imm=00AA, pc_buf=1.
  - Stimulus: then reset asserted during IMM.
  - Required: all outputs 0, and the next imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: two-word opcodes, NOP encoding and FSM state type.
// The control unit imports the same opcode constants so both stages agree on instruction length.
package fetch_pkg;

    localparam logic [4:0]  OPC_LDM   = 5'b10100;
    localparam logic [4:0]  OPC_LDD   = 5'b10101;
    localparam logic [4:0]  OPC_STD   = 5'b10110;
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        IMM   = 1'b1
    } fetch_state_e;

    function automatic logic is_two_word(input logic [4:0] opcode);
        return (opcode == OPC_LDM) || (opcode == OPC_LDD) || (opcode == OPC_STD);
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_buffer.sv
// IF/ID pipeline register. Flush wins over hold so a redirect always clears the entry;
// pc_buf is left untouched by a flush because a bubble carries no return address.
module if_id_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              flush,
    input  logic [15:0]       in_instr,
    input  logic [15:0]       in_imm,
    input  logic [ADDR_W-1:0] in_pc,
    output logic [15:0]       instruction,
    output logic [15:0]       imm,
    output logic [ADDR_W-1:0] pc_buf,
    output logic              valid_buf
);

    logic [15:0]       instr_q,  instr_d;
    logic [15:0]       imm_q,    imm_d;
    logic [ADDR_W-1:0] pc_buf_q, pc_buf_d;
    logic              valid_q,  valid_d;

    always_comb begin
        instr_d  = instr_q;
        imm_d    = imm_q;
        pc_buf_d = pc_buf_q;
        valid_d  = valid_q;
        if (flush) begin
            instr_d = NOP_INSTR;
            imm_d   = 16'h0000;
            valid_d = 1'b0;
        end else if (!hold) begin
            instr_d  = in_instr;
            imm_d    = in_imm;
            pc_buf_d = in_pc;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q  <= NOP_INSTR;
            imm_q    <= 16'h0000;
            pc_buf_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            instr_q  <= instr_d;
            imm_q    <= imm_d;
            pc_buf_q <= pc_buf_d;
            valid_q  <= valid_d;
        end
    end

    assign instruction = instr_q;
    assign imm         = imm_q;
    assign pc_buf      = pc_buf_q;
    assign valid_buf   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, assembles two-word instructions in a FETCH/IMM FSM
// and feeds the IF/ID buffer. Priority per edge: reset > jump > stall > normal.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              jump_occured,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    output logic [15:0]       instruction,
    output logic [15:0]       imm,
    output logic [ADDR_W-1:0] pc_buf,
    output logic              valid_buf
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] pc_q, pc_d;
    fetch_state_e      state_q, state_d;
    logic [15:0]       hold_word_q, hold_word_d;

    logic [ADDR_W-1:0] pc_inc;
    logic              two_word;
    logic              bubble;
    logic              buf_flush;
    logic [15:0]       buf_instr;
    logic [15:0]       buf_imm;

    assign pc_inc   = pc_q + PC_ONE;
    assign two_word = is_two_word(imem_data[15:11]);

    // First word of a two-word instruction sends a bubble downstream while the immediate is fetched.
    assign bubble    = !jump_occured && !stall && (state_q == FETCH) && two_word;
    assign buf_flush = jump_occured || bubble;
    assign buf_instr = (state_q == IMM) ? hold_word_q : imem_data;
    assign buf_imm   = (state_q == IMM) ? imem_data   : 16'h0000;

    always_comb begin
        pc_d        = pc_q;
        state_d     = state_q;
        hold_word_d = hold_word_q;
        if (jump_occured) begin
            pc_d    = jump_target;
            state_d = FETCH;
        end else if (!stall) begin
            pc_d = pc_inc;
            case (state_q)
                FETCH: begin
                    if (two_word) begin
                        hold_word_d = imem_data;
                        state_d     = IMM;
                    end
                end
                IMM:     state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            state_q     <= FETCH;
            hold_word_q <= 16'h0000;
        end else begin
            pc_q        <= pc_d;
            state_q     <= state_d;
            hold_word_q <= hold_word_d;
        end
    end

    assign imem_addr = pc_q;

    if_id_buffer #(
        .ADDR_W (ADDR_W)
    ) u_if_id (
        .clk         (clk),
        .reset       (reset),
        .hold        (stall),
        .flush       (buf_flush),
        .in_instr    (buf_instr),
        .in_imm      (buf_imm),
        .in_pc       (pc_inc),
        .instruction (instruction),
        .imm         (imm),
        .pc_buf      (pc_buf),
        .valid_buf   (valid_buf)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a table of per-cycle vectors whose expected IF/ID
// contents go through a scoreboard queue, plus a hand-written wrap/reset-in-IMM sequence.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        jump_occured;
    logic [15:0] jump_target;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] instruction;
    logic [15:0] imm;
    logic [15:0] pc_buf;
    logic        valid_buf;

    logic [15:0] imem [0:65535];

    typedef struct {
        logic        rst;
        logic        stall;
        logic        jump;
        logic [15:0] target;
        logic [15:0] addr;
        logic [15:0] instr;
        logic [15:0] imm;
        logic [15:0] pcb;
        logic        valid;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_data = imem[imem_addr];

    fetch_stage #(
        .ADDR_W   (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .jump_occured (jump_occured),
        .jump_target  (jump_target),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .instruction  (instruction),
        .imm          (imm),
        .pc_buf       (pc_buf),
        .valid_buf    (valid_buf)
    );

    function automatic vec_t mk(input logic rst, input logic stl, input logic jmp,
                                input logic [15:0] tgt, input logic [15:0] addr,
                                input logic [15:0] ins, input logic [15:0] im,
                                input logic [15:0] pcb, input logic vld);
        vec_t v;
        v.rst = rst; v.stall = stl; v.jump = jmp; v.target = tgt;
        v.addr = addr; v.instr = ins; v.imm = im; v.pcb = pcb; v.valid = vld;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, required %h", name, idx, act, req);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        reset        = v.rst;
        stall        = v.stall;
        jump_occured = v.jump;
        jump_target  = v.target;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        stall        = 1'b0;
        jump_occured = 1'b0;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard step %0d: got empty queue, required an entry", idx);
        end else begin
            e = exp_q.pop_front();
            $display("step %0d rst=%0b stall=%0b jump=%0b addr=%h instr=%h imm=%h pc_buf=%h valid=%0b",
                     idx, e.rst, e.stall, e.jump, imem_addr, instruction, imm, pc_buf, valid_buf);
            check("imem_addr",   idx, imem_addr,          e.addr);
            check("instruction", idx, instruction,        e.instr);
            check("imm",         idx, imm,                e.imm);
            check("pc_buf",      idx, pc_buf,             e.pcb);
            check("valid_buf",   idx, {15'h0, valid_buf}, {15'h0, e.valid});
        end
    endtask

    initial begin
        int poke_idx;
        for (int a = 0; a < 65536; a++) imem[a] = 16'h0000;
        imem[16'h0000] = 16'h0800; imem[16'h0001] = 16'h1000;
        imem[16'h0002] = 16'h1800; imem[16'h0003] = 16'h9800;
        imem[16'h0004] = 16'hA200; imem[16'h0005] = 16'h1234;
        imem[16'h0006] = 16'h2800; imem[16'h0007] = 16'h3000;
        imem[16'h0010] = 16'h4800; imem[16'h0011] = 16'hB000;
        imem[16'h0012] = 16'hBEEF; imem[16'h0013] = 16'hB800;
        imem[16'h0040] = 16'h4000; imem[16'h0041] = 16'hA000;
        imem[16'h0042] = 16'h5555; imem[16'hFFFF] = 16'hA800;

        //                 rst   stall jump  target    addr      instr     imm       pc_buf    valid
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'h0800, 16'h0000, 16'h0001, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 16'h1000, 16'h0000, 16'h0002, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0003, 16'h1800, 16'h0000, 16'h0003, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 16'h9800, 16'h0000, 16'h0004, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 16'h0004, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0006, 16'hA200, 16'h1234, 16'h0006, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0006, 16'hA200, 16'h1234, 16'h0006, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0006, 16'hA200, 16'h1234, 16'h0006, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0006, 16'hA200, 16'h1234, 16'h0006, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0007, 16'h2800, 16'h0000, 16'h0007, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 16'h0040, 16'h0040, 16'h0000, 16'h0000, 16'h0007, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0041, 16'h4000, 16'h0000, 16'h0041, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0042, 16'h0000, 16'h0000, 16'h0041, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0010, 16'h0000, 16'h0000, 16'h0041, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0011, 16'h4800, 16'h0000, 16'h0011, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0012, 16'h0000, 16'h0000, 16'h0011, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0012, 16'h0000, 16'h0000, 16'h0011, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0013, 16'hB000, 16'hBEEF, 16'h0013, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0014, 16'hB800, 16'h0000, 16'h0014, 1'b1));
        poke_idx = vecs.size();
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0014, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0014, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'hA800, 16'h00AA, 16'h0001, 1'b1));

        reset        = 1'b1;
        stall        = 1'b0;
        jump_occured = 1'b0;
        jump_target  = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_addr",   0, imem_addr,          16'h0000);
        check("reset_instr",  0, instruction,        16'h0000);
        check("reset_imm",    0, imm,                16'h0000);
        check("reset_pc_buf", 0, pc_buf,             16'h0000);
        check("reset_valid",  0, {15'h0, valid_buf}, 16'h0000);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == poke_idx) imem[16'h0000] = 16'h00AA;
            apply(vecs[i], i + 1);
        end

        // Reset while the immediate is pending: the half-built LDD must never surface.
        apply(mk(1'b0, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0001, 1'b0), 100);
        apply(mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 1'b0), 101);
        apply(mk(1'b1, 1'b1, 1'b1, 16'h0123, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0), 102);
        apply(mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'h00AA, 16'h0000, 16'h0001, 1'b1), 103);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
